// File: rtl/audio_pkg.sv
// Shared definitions for the audio pump: register map, status bits,
// command words and the pump state encoding.
package audio_pkg;

  // Audio interface register addresses
  localparam logic [2:0] ADDR_DAC_L  = 3'd0;
  localparam logic [2:0] ADDR_DAC_R  = 3'd1;
  localparam logic [2:0] ADDR_ADC_L  = 3'd2;
  localparam logic [2:0] ADDR_ADC_R  = 3'd3;
  localparam logic [2:0] ADDR_CMD    = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  // Status register bit positions
  localparam int STAT_DAC_FULL  = 0;
  localparam int STAT_ADC_EMPTY = 1;

  // Command word that clears both audio FIFOs
  localparam logic [15:0] CMD_CLEAR = 16'h0001;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CLEAR    = 4'd1,
    ST_POLL     = 4'd2,
    ST_DECIDE   = 4'd3,
    ST_DAC_L    = 4'd4,
    ST_DAC_R    = 4'd5,
    ST_ADC_L    = 4'd6,
    ST_ADC_WAIT = 4'd7,
    ST_ADC_R    = 4'd8,
    ST_CAP      = 4'd9,
    ST_GAP      = 4'd10
  } pump_state_e;

  // Side served most recently, used to break DAC/ADC ties
  typedef enum logic {
    SRV_DAC = 1'b0,
    SRV_ADC = 1'b1
  } srv_side_e;

endpackage

// File: rtl/audio_pump.sv
// Autonomous Avalon-MM master that polls the audio interface status and
// moves stereo frames source->DAC FIFO and ADC FIFO->capture sink,
// alternating DAC/ADC service when both sides need attention.
// All outputs are registered: each output register is loaded from the
// decode of the next state, so a strobe is high exactly while the state
// register holds the matching state.
module audio_pump
  import audio_pkg::*;
#(
  parameter int POLL_GAP   = 4,
  parameter int ADC_LR_GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clear_req,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [15:0] src_left,
  input  logic [15:0] src_right,
  output logic        cap_valid,
  input  logic        cap_ready,
  output logic [15:0] cap_left,
  output logic [15:0] cap_right,
  output logic [2:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  output logic        busy,
  output logic [15:0] dac_frames,
  output logic [15:0] adc_frames
);

  // Last in-state count value before leaving the timed idle states
  localparam logic [15:0] GAP_LAST = 16'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [15:0] LR_LAST  = 16'((ADC_LR_GAP > 0) ? ADC_LR_GAP - 1 : 0);

  pump_state_e state_r, next_state_s, gap_exit_s, gap_entry_s;
  srv_side_e   last_srv_r;
  logic [15:0] wait_cnt_r;
  logic        clear_pend_r, clr_any_s;
  logic        dac_full_r, adc_empty_r;
  logic        need_dac_s, need_adc_s;
  logic [15:0] dac_right_r, adc_left_r;

  logic        read_s, write_s, src_ready_s, cap_valid_s;
  logic [2:0]  addr_s;
  logic [15:0] wdata_s, cap_left_s, cap_right_s;

  assign clr_any_s  = clear_pend_r | clear_req;
  assign need_dac_s = ~dac_full_r & src_valid;
  assign need_adc_s = ~adc_empty_r & cap_ready;

  // Where a service slot goes once its idle gap has elapsed
  always_comb begin
    if (!en) begin
      gap_exit_s = ST_IDLE;
    end else if (clr_any_s) begin
      gap_exit_s = ST_CLEAR;
    end else begin
      gap_exit_s = ST_POLL;
    end
  end

  // With a zero-length gap the GAP state is skipped entirely
  always_comb begin
    if (POLL_GAP == 0) begin
      gap_entry_s = gap_exit_s;
    end else begin
      gap_entry_s = ST_GAP;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a started frame always runs to completion
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en || clr_any_s) next_state_s = ST_CLEAR;
        else                 next_state_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (en) next_state_s = ST_POLL;
        else    next_state_s = ST_IDLE;
      end
      ST_POLL: begin
        if (en) next_state_s = ST_DECIDE;
        else    next_state_s = ST_IDLE;
      end
      ST_DECIDE: begin
        if (!en)                          next_state_s = ST_IDLE;
        else if (clr_any_s)               next_state_s = ST_CLEAR;
        else if (need_dac_s && need_adc_s)
          next_state_s = (last_srv_r == SRV_ADC) ? ST_DAC_L : ST_ADC_L;
        else if (need_dac_s)              next_state_s = ST_DAC_L;
        else if (need_adc_s)              next_state_s = ST_ADC_L;
        else                              next_state_s = gap_entry_s;
      end
      ST_DAC_L:    next_state_s = ST_DAC_R;
      ST_DAC_R:    next_state_s = gap_entry_s;
      ST_ADC_L:    next_state_s = ST_ADC_WAIT;
      ST_ADC_WAIT: begin
        if (wait_cnt_r == LR_LAST) next_state_s = ST_ADC_R;
        else                       next_state_s = ST_ADC_WAIT;
      end
      ST_ADC_R:    next_state_s = ST_CAP;
      ST_CAP:      next_state_s = gap_entry_s;
      ST_GAP: begin
        if (wait_cnt_r == GAP_LAST) next_state_s = gap_exit_s;
        else                        next_state_s = ST_GAP;
      end
      default:     next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the state about to be entered
  always_comb begin
    read_s      = 1'b0;
    write_s     = 1'b0;
    addr_s      = avm_address;
    wdata_s     = avm_writedata;
    src_ready_s = 1'b0;
    cap_valid_s = 1'b0;
    cap_left_s  = cap_left;
    cap_right_s = cap_right;
    case (next_state_s)
      ST_CLEAR: begin
        write_s = 1'b1;
        addr_s  = ADDR_CMD;
        wdata_s = CMD_CLEAR;
      end
      ST_POLL: begin
        read_s = 1'b1;
        addr_s = ADDR_STATUS;
      end
      ST_DAC_L: begin
        write_s     = 1'b1;
        addr_s      = ADDR_DAC_L;
        wdata_s     = src_left;
        src_ready_s = 1'b1;
      end
      ST_DAC_R: begin
        write_s = 1'b1;
        addr_s  = ADDR_DAC_R;
        wdata_s = dac_right_r;
      end
      ST_ADC_L: begin
        read_s = 1'b1;
        addr_s = ADDR_ADC_L;
      end
      ST_ADC_R: begin
        read_s = 1'b1;
        addr_s = ADDR_ADC_R;
      end
      ST_CAP: begin
        // CAP is only entered from ADC_R, so readdata is the right word
        cap_valid_s = 1'b1;
        cap_left_s  = adc_left_r;
        cap_right_s = avm_readdata;
      end
      default: begin
        read_s  = 1'b0;
        write_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= 3'd0;
      avm_writedata <= 16'h0000;
      src_ready     <= 1'b0;
      cap_valid     <= 1'b0;
      cap_left      <= 16'h0000;
      cap_right     <= 16'h0000;
      busy          <= 1'b0;
    end else begin
      avm_read      <= read_s;
      avm_write     <= write_s;
      avm_address   <= addr_s;
      avm_writedata <= wdata_s;
      src_ready     <= src_ready_s;
      cap_valid     <= cap_valid_s;
      cap_left      <= cap_left_s;
      cap_right     <= cap_right_s;
      busy          <= (next_state_s != ST_IDLE);
    end
  end

  // Cycles spent in the current state, restarted on every transition
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= 16'd0;
    end else if (next_state_s != state_r) begin
      wait_cnt_r <= 16'd0;
    end else begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end
  end

  // Sticky one-deep clear request, consumed by the CLEAR write
  always_ff @(posedge clk) begin
    if (reset) begin
      clear_pend_r <= 1'b0;
    end else if (state_r == ST_CLEAR) begin
      clear_pend_r <= 1'b0;
    end else if (clear_req) begin
      clear_pend_r <= 1'b1;
    end else begin
      clear_pend_r <= clear_pend_r;
    end
  end

  // Status bits captured at the end of the poll read
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_full_r  <= 1'b1;
      adc_empty_r <= 1'b1;
    end else if (state_r == ST_POLL) begin
      dac_full_r  <= avm_readdata[STAT_DAC_FULL];
      adc_empty_r <= avm_readdata[STAT_ADC_EMPTY];
    end else begin
      dac_full_r  <= dac_full_r;
      adc_empty_r <= adc_empty_r;
    end
  end

  // Round-robin memory: remember which side was granted last
  always_ff @(posedge clk) begin
    if (reset) begin
      last_srv_r <= SRV_ADC;
    end else if (state_r == ST_DAC_L) begin
      last_srv_r <= SRV_DAC;
    end else if (state_r == ST_ADC_L) begin
      last_srv_r <= SRV_ADC;
    end else begin
      last_srv_r <= last_srv_r;
    end
  end

  // Frame data holding: right DAC word taken with the left, ADC left word
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_right_r <= 16'h0000;
      adc_left_r  <= 16'h0000;
    end else begin
      if (next_state_s == ST_DAC_L) dac_right_r <= src_right;
      else                          dac_right_r <= dac_right_r;
      if (state_r == ST_ADC_L) adc_left_r <= avm_readdata;
      else                     adc_left_r <= adc_left_r;
    end
  end

  // Wrapping frame counters, zeroed by a FIFO clear
  always_ff @(posedge clk) begin
    if (reset || (state_r == ST_CLEAR)) begin
      dac_frames <= 16'h0000;
      adc_frames <= 16'h0000;
    end else begin
      if (state_r == ST_DAC_R) dac_frames <= dac_frames + 16'h0001;
      else                     dac_frames <= dac_frames;
      if (state_r == ST_CAP) adc_frames <= adc_frames + 16'h0001;
      else                   adc_frames <= adc_frames;
    end
  end

endmodule

// File: doc/audio_pump.md
# audio_pump

Autonomous Avalon-MM master that services the audio interface's register port without CPU involvement. It polls the status register and moves stereo frames from a sample source (wave generator) into the DAC FIFO and from the ADC FIFO to a capture sink. DAC and ADC service are arbitrated round-robin, one frame per grant. It sits between the wave-generation datapath and the audio interface slave, replacing software polling.

## Interface
- POLL_GAP, 4: idle cycles between the end of one service slot and the next status poll (≥0).
- ADC_LR_GAP, 2: idle cycles between the ADC-left read and the ADC-right read (≥1).
- clk  in  1  system clock; same clock as the audio interface.
- reset  in  1  synchronous, active-high.
- en  in  1  level; pump runs while high.
- clear_req  in  1  pulse; request a FIFO clear.
- src_valid / src_ready  in/out  1  sample-source handshake.
- src_left, src_right  in  16 each  DAC frame.
- cap_valid / cap_ready  out/in  1  capture-sink handshake.
- cap_left, cap_right  out  16 each  ADC frame.
- avm_address  out  3  register address: 0 DAC-L, 1 DAC-R, 2 ADC-L, 3 ADC-R, 4 CMD, 5 STATUS.
- avm_read, avm_write  out  1  single-cycle strobes, never both high.
- avm_writedata  out  16.
- avm_readdata  in  16  valid at the clock edge that ends the read cycle (zero wait, zero latency).
- busy  out  1  high in any state other than IDLE.
- dac_frames, adc_frames  out  16 each  wrapping frame counters.

## Operation
- States: IDLE, CLEAR, POLL, DECIDE, DAC_L, DAC_R, ADC_L, ADC_WAIT, ADC_R, CAP, GAP.
- IDLE:
  - If en=1 → CLEAR (a clear is always issued on start).
  - A clear_req seen in IDLE also → CLEAR; afterwards go to POLL if en=1, else back to IDLE.
- CLEAR: one write, address 4, data 0x0001. Clears both frame counters. Then → POLL.
- POLL: one read, address 5; latch dac_full=readdata[0], adc_empty=readdata[1]. Then → DECIDE.
- DECIDE (no bus activity):
  - need_dac = !dac_full & src_valid.
  - need_adc = !adc_empty & cap_ready.
  - Both set: grant the side not served last (last_srv flag, reset value = ADC, so DAC wins the first tie).
  - Neither set: → GAP.
  - A clear_req latched since the last decision takes priority over both → CLEAR.
- DAC_L:
  - Write address 0 with src_left; src_ready=1 this cycle; src_right captured into a register.
  - → DAC_R: write address 1 with the captured right word; dac_frames+1.
  - → GAP.
- ADC_L: read address 2; readdata is latched as left.
- ADC_WAIT: ADC_LR_GAP cycles with no bus activity.
- ADC_R: read address 3; readdata is latched as right.
- CAP: cap_valid=1 for exactly one cycle; adc_frames+1. cap_ready is not re-checked here, because it was qualified in DECIDE and the sink must accept once it has asserted ready. → GAP.
- GAP: POLL_GAP idle cycles, then:
  - → IDLE if en=0;
  - → CLEAR if clear_req is pending;
  - otherwise → POLL.
- en falling mid-frame: the current frame always completes. Only GAP, DECIDE and POLL check en; a frame is never split.
- clear_req: a 1-deep sticky flag. Multiple pulses before service collapse into one CLEAR.

## Timing
- Reset values:
  - state=IDLE.
  - avm_read=0, avm_write=0, avm_address=0, avm_writedata=0.
  - src_ready=0, cap_valid=0, cap_left=0, cap_right=0, busy=0.
  - dac_frames=0, adc_frames=0, last_srv=ADC, clear pending=0.
- All outputs are registered. Each bus access occupies exactly one cycle.
- DAC service: POLL→DECIDE→DAC_L→DAC_R = 4 cycles from poll to last write, plus POLL_GAP.
- ADC service: POLL, DECIDE, ADC_L, ADC_LR_GAP wait cycles, ADC_R, CAP = 5+ADC_LR_GAP cycles. cap_valid rises the cycle after the ADC-R read.
- Minimum loop period with POLL_GAP=0 and a DAC grant: 4 cycles.
- Counters wrap at 0xFFFF→0x0000 and are not saturating.
- reset asserted mid-frame: abort immediately, all strobes drop next edge, no partial-frame completion.

## Structure
- Shared package audio_pkg holds:
  - register address constants (DAC_L=0 … STATUS=5);
  - status bit indices (DAC_FULL=0, ADC_EMPTY=1);
  - CMD_CLEAR=16'h0001;
  - the state encoding.
- Single module with no sub-module: the arbiter is one flag and the counters are inline.

## Test plan
- Start-up: assert en with src_valid=1 and status=0x0002 → write addr4=0x0001, read addr5, write addr0=src_left, write addr1=src_right; dac_frames=1.
- Tie arbitration: status=0x0000, src_valid=1, cap_ready=1 for 4 polls → grants alternate DAC, ADC, DAC, ADC; dac_frames=2, adc_frames=2.
- ADC path: readdata 0x1234 on the addr2 read and 0xABCD on the addr3 read, ADC_LR_GAP=2 → exactly 2 idle cycles between the reads; one-cycle cap_valid with cap_left=0x1234, cap_right=0xABCD.
- Backpressure: status=0x0003 (full, empty) → only status polls spaced POLL_GAP+2 cycles apart; no writes, src_ready stays 0.
- Clear mid-frame: clear_req pulsed twice during DAC_L → frame completes, then exactly one CMD write of 0x0001, counters=0, then POLL.
- Reset mid ADC_WAIT → next cycle all strobes 0, state IDLE, cap_valid never asserted.
